aes_key_expand_seq: RTL and testbench
=====================================

// Module: aes_key_expand_seq
// PURPOSE
//  Sequential AES key-schedule engine for AES-128/192/256, mode chosen per key at run time.
//  Generates one 32-bit schedule word per clock into an internal word store, then serves round keys on request.
//  Sits between key load logic and the AES round datapath (encrypt/decrypt), replacing the combinational all-rounds expander.
// PARAMETERS
//  NK_MAX   8   largest key length in 32-bit words (fixed: AES-256)
//  NR_MAX   14  largest round count; word store depth = 4*(NR_MAX+1) = 60
// PORTS
//  clk       in   1    single clock, rising edge
//  rst       in   1    synchronous reset, active-high
//  start     in   1    load key_in/key_len and begin expansion (accepted only in IDLE)
//  key_len   in   2    00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//  key_in    in   256  key, MSB-aligned: w[0]=key_in[255:224]; 128/192 use the top 128/192 bits
//  busy      out  1    expansion in progress
//  done      out  1    one-cycle pulse when the last word is written
//  key_ready out  1    level: schedule complete and valid for the current key
//  nr        out  4    rounds for the loaded mode (10/12/14); 0 after reset
//  rk_rd     in   1    round-key read request
//  rk_idx    in   4    round number 0..nr
//  rk_vld    out  1    read response valid, 1 cycle after rk_rd
//  rk_err    out  1    with rk_vld: request rejected
//  rk_data   out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}, MSB-first
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, key_ready, rk_vld, rk_err = 0; rk_data = 0; nr = 0. Word store is not cleared.
//  FSM IDLE -> LOAD -> GEN -> IDLE.
//   IDLE: start && key_len!=11 -> LOAD. Latch nk (4/6/8) and nr (10/12/14). Clear key_ready.
//     start with key_len==11 -> stay IDLE; done pulses and key_ready=0.
//   LOAD, 1 cycle: write w[0..nk-1] from key_in. Set i=nk, j=0 (j tracks i mod nk), rcon=8'h01. busy=1.
//   GEN, 1 word/cycle, t=w[i-1]:
//     j==0        : t = SubWord(RotWord(t)) ^ {rcon,24'h0}; rcon <= xtime(rcon) (0x80 -> 0x1b).
//     nk==8, j==4 : t = SubWord(t).
//     w[i] = w[i-nk] ^ t; i++; j = (j==nk-1) ? 0 : j+1. No divider and no modulo operator.
//     Exit after i = 4*(nr+1)-1 is written: done=1 for that one cycle, key_ready=1, busy=0.
//  GEN cycle counts: 40/46/52. Start-to-done latency: 41/47/53 cycles after the start edge.
//  start while busy: ignored. start in IDLE with key_ready=1: re-expands; key_ready drops the next cycle.
//  Read port (active in any state):
//   rk_rd && key_ready && rk_idx<=nr -> next cycle rk_vld=1, rk_err=0, rk_data=round key.
//   Otherwise -> rk_vld=1, rk_err=1, rk_data=0.
//   rk_data holds its value when rk_rd=0. rk_vld/rk_err are single-cycle.
//  rst during LOAD/GEN: back to IDLE next edge, key_ready=0, no done pulse. Partial store contents are never served.
//  Widths: i is 6 bits, j is 3 bits, rcon is 8 bits. All XOR is bitwise on 32-bit words.
// STRUCTURE
//  Shared package aes_pkg:
//   - key_len_e enum
//   - NK/NR lookup functions
//   - xtime() function
//   - 256-entry SBOX constant table
//   - rot_word() / sub_word() functions, reused by the cipher datapath
//  Sub-module aes_sbox32: four parallel byte S-box lookups, combinational. One instance in GEN.
//  Word store: 60x32 register array, 1 write/cycle, 4-word read.
// TESTING
//  FIPS-197 A.1, 128-bit, key 2b7e151628aed2a6abf7158809cf4f3c -> done 41 cycles after start;
//   rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//  FIPS-197 A.2, 192-bit, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> nr=12;
//   rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
//  FIPS-197 A.3, 256-bit, key 603deb10...0914dff4 -> nr=14, done after 53 cycles;
//   rk_idx=14 -> fe4890d1e6188d0b046df344706c631e. rk_idx=0 returns the key's top 128 bits.
//  Bad requests: rk_rd during GEN -> rk_err=1. rk_idx=11 in 128 mode -> rk_err=1, rk_data=0.
//   key_len=11 -> done pulse, key_ready=0.
//  Reset mid-GEN at cycle 20 -> no done pulse, key_ready=0.
//   Then restart with A.1 -> correct keys. start pulses during busy are ignored (done count = 1).
//  Back-to-back: A.3 then A.1 without reset -> nr=10; round 10 key matches A.1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: key-length encoding, NK/NR lookup, GF(2^8) doubling,
// the forward S-box and the word-level rotate/substitute used by the cipher.
package aes_pkg;

   typedef enum logic [1:0] {
      KL_128 = 2'b00,
      KL_192 = 2'b01,
      KL_256 = 2'b10,
      KL_BAD = 2'b11
   } key_len_e;

   localparam int NK_MAX = 8;
   localparam int NR_MAX = 14;

   function automatic logic [3:0] nk_of(input key_len_e kl);
      case (kl)
         KL_128:  return 4'd4;
         KL_192:  return 4'd6;
         default: return 4'd8;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input key_len_e kl);
      case (kl)
         KL_128:  return 4'd10;
         KL_192:  return 4'd12;
         default: return 4'd14;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

endpackage

// File: rtl/aes_sbox32.sv
// Four parallel byte S-box lookups on a 32-bit word, purely combinational.
module aes_sbox32
   import aes_pkg::*;
(
   input  logic [31:0] din,
   output logic [31:0] dout
);

   for (genvar b = 0; b < 4; b++) begin : g_byte
      assign dout[8*b +: 8] = SBOX[din[8*b +: 8]];
   end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule: one schedule word per clock into a
// 60-word store, then 128-bit round keys served with one cycle of latency.
module aes_key_expand_seq
   import aes_pkg::*;
#(
   parameter int NK_MAX = 8,
   parameter int NR_MAX = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            key_len,
   input  logic [32*NK_MAX-1:0]  key_in,
   output logic                  busy,
   output logic                  done,
   output logic                  key_ready,
   output logic [3:0]            nr,
   input  logic                  rk_rd,
   input  logic [3:0]            rk_idx,
   output logic                  rk_vld,
   output logic                  rk_err,
   output logic [127:0]          rk_data
);

   localparam int WORDS = 4 * (NR_MAX + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_GEN} state_e;

   state_e      state;
   key_len_e    kl;
   logic [3:0]  nk;
   logic [5:0]  i;
   logic [2:0]  j;
   logic [7:0]  rcon;
   logic [31:0] w [WORDS];

   logic        accept;
   logic [5:0]  last_i;
   logic [31:0] prev, back, sb_in, sb_out, t, new_word;
   logic [5:0]  rd_base;

   assign kl      = key_len_e'(key_len);
   assign accept  = (state == ST_IDLE) && start && (kl != KL_BAD);
   assign last_i  = {nr, 2'b11};
   assign rd_base = {rk_idx, 2'b00};

   assign prev  = w[i - 6'd1];
   assign back  = w[i - {2'b00, nk}];
   assign sb_in = (j == 3'd0) ? rot_word(prev) : prev;

   aes_sbox32 u_sbox (.din(sb_in), .dout(sb_out));

   always_comb begin
      t = prev;
      if (j == 3'd0)
         t = sb_out ^ {rcon, 24'h0};
      else if (nk == 4'd8 && j == 3'd4)
         t = sb_out;
      new_word = back ^ t;
   end

   // Key words land in the store on the accept edge, so key_in only has to be
   // valid alongside start; LOAD then just primes the generation counters.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < NK_MAX; k++)
            if (k < int'(nk_of(kl)))
               w[k] <= key_in[32*NK_MAX-1-32*k -: 32];
      end
      if (state == ST_GEN)
         w[i] <= new_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         key_ready <= 1'b0;
         nr        <= 4'd0;
         nk        <= 4'd0;
         i         <= 6'd0;
         j         <= 3'd0;
         rcon      <= 8'h00;
         rk_vld    <= 1'b0;
         rk_err    <= 1'b0;
         rk_data   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  key_ready <= 1'b0;
                  if (kl == KL_BAD) begin
                     done <= 1'b1;
                  end else begin
                     nk    <= nk_of(kl);
                     nr    <= nr_of(kl);
                     busy  <= 1'b1;
                     state <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               i     <= {2'b00, nk};
               j     <= 3'd0;
               rcon  <= 8'h01;
               state <= ST_GEN;
            end
            ST_GEN: begin
               if (j == 3'd0)
                  rcon <= xtime(rcon);
               if (i == last_i) begin
                  done      <= 1'b1;
                  key_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  i <= i + 6'd1;
                  j <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Read port runs in every state; key_ready gates out stale or partial words.
         rk_vld <= rk_rd;
         rk_err <= 1'b0;
         if (rk_rd) begin
            if (key_ready && rk_idx <= nr) begin
               rk_data <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
            end else begin
               rk_err  <= 1'b1;
               rk_data <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: FIPS-197 vectors plus random keys checked against
// a schedule model whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_key_expand_seq;

   logic         clk = 1'b0;
   logic         rst, start, rk_rd;
   logic [1:0]   key_len;
   logic [255:0] key_in;
   logic [3:0]   rk_idx, nr;
   logic         busy, done, key_ready, rk_vld, rk_err;
   logic [127:0] rk_data;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int done_cnt = 0;

   logic [7:0]  msbox [256];
   logic [31:0] mw [60];

   localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK_A1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RK_A2_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] RK_A3_14 = 128'hfe4890d1e6188d0b046df344706c631e;
   localparam logic [127:0] RK_A3_0  = 128'h603deb1015ca71be2b73aef0857d7781;

   aes_key_expand_seq dut (
      .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
      .busy(busy), .done(done), .key_ready(key_ready), .nr(nr),
      .rk_rd(rk_rd), .rk_idx(rk_idx), .rk_vld(rk_vld), .rk_err(rk_err), .rk_data(rk_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done) done_cnt++;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [7:0] r = x;
      for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         msbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] msub(input logic [31:0] v);
      return {msbox[v[31:24]], msbox[v[23:16]], msbox[v[15:8]], msbox[v[7:0]]};
   endfunction

   task automatic model_expand(input logic [255:0] key, input int nk);
      logic [7:0]  rc = 8'h01;
      logic [31:0] t;
      for (int k = 0; k < nk; k++) mw[k] = key[255-32*k -: 32];
      for (int k = nk; k < 4 * (nk + 7); k++) begin
         t = mw[k-1];
         if (k % nk == 0) begin
            t  = msub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk == 8 && k % nk == 4) begin
            t = msub(t);
         end
         mw[k] = mw[k-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] mkey(input int r);
      return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_exp(input logic [1:0] kl, input logic [255:0] k);
      key_len = kl;
      key_in  = k;
      start   = 1'b1;
      tick();
      start  = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 200) begin
         tick();
         cyc++;
      end
      chk_cnt++;
      if (!done) $display("FAIL wait_done: no done within %0d cycles", cyc);
      else pass_cnt++;
   endtask

   task automatic read_rk(input logic [3:0] idx, output logic v, output logic e, output logic [127:0] d);
      rk_rd  = 1'b1;
      rk_idx = idx;
      tick();
      rk_rd = 1'b0;
      v = rk_vld;
      e = rk_err;
      d = rk_data;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic v, e; logic [127:0] d;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      chk_cnt++;
      if ({busy, done, key_ready, rk_vld, rk_err, nr, rk_data} !== '0)
         $display("FAIL reset_outputs: got busy=%b done=%b kr=%b vld=%b err=%b nr=%0d data=%h, want all 0",
                  busy, done, key_ready, rk_vld, rk_err, nr, rk_data);
      else pass_cnt++;
      read_rk(4'd0, v, e, d);
      chk_cnt++;
      if ({v, e, d} !== {2'b11, 128'h0}) $display("FAIL reset_read: got vld=%b err=%b data=%h, want 1 1 0", v, e, d);
      else pass_cnt++;
   endtask

   task automatic test_fips(input logic [1:0] kl, input logic [255:0] k, input int exp_cyc,
                            input logic [3:0] exp_nr, input logic [127:0] exp_rk);
      int cyc; logic v, e; logic [127:0] d;
      start_exp(kl, k);
      wait_done(cyc);
      chk_cnt++;
      if (cyc != exp_cyc) $display("FAIL fips_latency: got %0d cycles, want %0d", cyc, exp_cyc);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({done, busy, key_ready, nr} !== {3'b001, exp_nr})
         $display("FAIL fips_status: got done=%b busy=%b kr=%b nr=%0d, want 0 0 1 %0d", done, busy, key_ready, nr, exp_nr);
      else pass_cnt++;
      read_rk(exp_nr, v, e, d);
      chk_cnt++;
      if ({v, e, d} !== {2'b10, exp_rk}) $display("FAIL fips_last_rk: got vld=%b err=%b data=%h, want 1 0 %h", v, e, d, exp_rk);
      else pass_cnt++;
   endtask

   task automatic test_rk0_256();
      logic v, e; logic [127:0] d;
      read_rk(4'd0, v, e, d);
      chk_cnt++;
      if ({v, e, d} !== {2'b10, RK_A3_0}) $display("FAIL rk0_256: got %b %b %h, want 1 0 %h", v, e, d, RK_A3_0);
      else pass_cnt++;
   endtask

   task automatic test_bad_requests();
      int cyc; logic v, e; logic [127:0] d;
      start_exp(2'b11, KEY_A1);
      chk_cnt++;
      if ({done, key_ready, busy} !== 3'b100) $display("FAIL bad_keylen: got done=%b kr=%b busy=%b, want 1 0 0", done, key_ready, busy);
      else pass_cnt++;
      start_exp(2'b00, KEY_A1);
      tick(); tick(); tick();
      read_rk(4'd1, v, e, d);
      chk_cnt++;
      if ({v, e, d} !== {2'b11, 128'h0}) $display("FAIL read_during_gen: got %b %b %h, want 1 1 0", v, e, d);
      else pass_cnt++;
      wait_done(cyc);
      tick();
      read_rk(4'd11, v, e, d);
      chk_cnt++;
      if ({v, e, d} !== {2'b11, 128'h0}) $display("FAIL idx11_128: got %b %b %h, want 1 1 0", v, e, d);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_gen();
      int cyc; logic v, e; logic [127:0] d;
      start_exp(2'b10, KEY_A3);
      for (int k = 0; k < 20; k++) tick();
      done_cnt = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      for (int k = 0; k < 60; k++) tick();
      chk_cnt++;
      if ({done_cnt != 0, key_ready, busy, nr} !== 7'b0)
         $display("FAIL reset_mid_gen: got done_cnt=%0d kr=%b busy=%b nr=%0d, want 0 0 0 0", done_cnt, key_ready, busy, nr);
      else pass_cnt++;
      done_cnt = 0;
      start_exp(2'b00, KEY_A1);
      for (int k = 0; k < 5; k++) tick();
      start_exp(2'b10, KEY_A3);
      for (int k = 0; k < 5; k++) tick();
      start_exp(2'b11, KEY_A2);
      wait_done(cyc);
      for (int k = 0; k < 4; k++) tick();
      chk_cnt++;
      if (done_cnt != 1 || nr !== 4'd10) $display("FAIL start_while_busy: got done_cnt=%0d nr=%0d, want 1 10", done_cnt, nr);
      else pass_cnt++;
      read_rk(4'd10, v, e, d);
      chk_cnt++;
      if ({v, e, d} !== {2'b10, RK_A1_10}) $display("FAIL restart_rk10: got %b %b %h, want 1 0 %h", v, e, d, RK_A1_10);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int cyc, nk, mnr; logic [1:0] kl; logic [255:0] k; logic [3:0] idx;
      logic v, e; logic [127:0] d, exp_d;
      for (int it = 0; it < 8; it++) begin
         k   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         kl  = 2'($urandom_range(0, 2));
         nk  = 4 + 2 * int'(kl);
         mnr = nk + 6;
         model_expand(k, nk);
         start_exp(kl, k);
         wait_done(cyc);
         chk_cnt++;
         if (cyc != 1 + 4 * (mnr + 1) - nk || nr !== 4'(mnr))
            $display("FAIL rand_latency_nr: got cyc=%0d nr=%0d, want %0d %0d", cyc, nr, 1 + 4 * (mnr + 1) - nk, mnr);
         else pass_cnt++;
         for (int r = 0; r < 4; r++) begin
            idx   = 4'($urandom_range(0, 15));
            exp_d = (int'(idx) <= mnr) ? mkey(int'(idx)) : 128'h0;
            read_rk(idx, v, e, d);
            chk_cnt++;
            if ({v, e, d} !== {1'b1, int'(idx) > mnr, exp_d})
               $display("FAIL rand_rk idx=%0d: got %b %b %h, want 1 %b %h", idx, v, e, d, int'(idx) > mnr, exp_d);
            else pass_cnt++;
         end
         tick();
         chk_cnt++;
         if ({rk_vld, rk_err, rk_data} !== {2'b00, exp_d})
            $display("FAIL rand_hold: got vld=%b err=%b data=%h, want 0 0 %h", rk_vld, rk_err, rk_data, exp_d);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int cyc; logic v, e; logic [127:0] d;
      test_fips(2'b10, KEY_A3, 53, 4'd14, RK_A3_14);
      start_exp(2'b00, KEY_A1);
      chk_cnt++;
      if ({key_ready, busy} !== 2'b01) $display("FAIL b2b_kr_drop: got kr=%b busy=%b, want 0 1", key_ready, busy);
      else pass_cnt++;
      wait_done(cyc);
      tick();
      read_rk(4'd10, v, e, d);
      chk_cnt++;
      if ({v, e, d, nr} !== {2'b10, RK_A1_10, 4'd10}) $display("FAIL b2b_rk10: got %b %b %h nr=%0d, want 1 0 %h 10", v, e, d, nr, RK_A1_10);
      else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rk_rd = 1'b0; key_len = 2'b00; key_in = '0; rk_idx = 4'd0;
      build_sbox();
      @(negedge clk);
      test_reset();
      test_fips(2'b00, KEY_A1, 41, 4'd10, RK_A1_10);
      test_fips(2'b01, KEY_A2, 47, 4'd12, RK_A2_12);
      test_fips(2'b10, KEY_A3, 53, 4'd14, RK_A3_14);
      test_rk0_256();
      test_bad_requests();
      test_reset_mid_gen();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
